// File: rtl/pwm_capture_if.sv
// Signal bundle between a PWM capture block and its user: enable and raw PWM in,
// measurement results and timeout status out.
interface pwm_capture_if #(
    parameter int CNT_W = 24
);
    logic             en;
    logic             pwm_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             timeout;
    logic             stuck_level;

    modport master (
        output en, pwm_in,
        input  period, high_time, meas_valid, timeout, stuck_level
    );

    modport slave (
        input  en, pwm_in,
        output period, high_time, meas_valid, timeout, stuck_level
    );
endinterface

// File: rtl/pwm_capture.sv
// Measures period and high time of an asynchronous PWM input in clk cycles,
// with a no-edge timeout that reports the level the input got stuck at.
module pwm_capture #(
    parameter int CNT_W   = 24,
    parameter int TIMEOUT = 2_500_000
) (
    input  logic         clk,
    input  logic         rstn,
    pwm_capture_if.slave bus
);

    localparam longint MAX_CNT = longint'((64'd1 << CNT_W) - 64'd1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    // The counter stops at TIMEOUT-1, so this bound guarantees it never wraps.
    generate
        if (TIMEOUT < 1 || longint'(TIMEOUT) > MAX_CNT) begin : g_bad_timeout
            $error("pwm_capture: TIMEOUT must lie in 1 .. 2**CNT_W-1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_ARM,
        S_HIGH,
        S_LOW
    } state_t;

    state_t           r_state;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_hist;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_pend_high;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high_time;
    logic             r_meas_valid;
    logic             r_timeout;
    logic             r_stuck_level;

    logic w_rise;
    logic w_fall;
    logic w_cnt_last;

    assign w_rise     = r_sync2 & ~r_hist;
    assign w_fall     = ~r_sync2 & r_hist;
    assign w_cnt_last = (r_cnt == TO_LAST);

    // NOTE: non-blocking assignments let the synchronizer shift exactly one stage per edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= S_ARM;
            r_sync1       <= 1'b0;
            r_sync2       <= 1'b0;
            r_hist        <= 1'b0;
            r_cnt         <= '0;
            r_pend_high   <= '0;
            r_period      <= '0;
            r_high_time   <= '0;
            r_meas_valid  <= 1'b0;
            r_timeout     <= 1'b0;
            r_stuck_level <= 1'b0;
        end else begin
            r_sync1      <= bus.pwm_in;
            r_sync2      <= r_sync1;
            r_hist       <= r_sync2;
            r_meas_valid <= 1'b0;

            if (!bus.en) begin
                r_state <= S_ARM;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    S_ARM: begin
                        if (w_rise) begin
                            r_cnt   <= '0;
                            r_state <= S_HIGH;
                        end
                    end
                    S_HIGH: begin
                        if (w_fall) begin
                            r_pend_high <= r_cnt + ONE;
                            r_cnt       <= r_cnt + ONE;
                            r_state     <= S_LOW;
                        end else if (w_cnt_last) begin
                            r_state       <= S_ARM;
                            r_timeout     <= 1'b1;
                            r_stuck_level <= r_sync2;
                        end else begin
                            r_cnt <= r_cnt + ONE;
                        end
                    end
                    S_LOW: begin
                        // A rise landing on the last count wins over the timeout.
                        if (w_rise) begin
                            r_period     <= r_cnt + ONE;
                            r_high_time  <= r_pend_high;
                            r_meas_valid <= 1'b1;
                            r_timeout    <= 1'b0;
                            r_cnt        <= '0;
                            r_state      <= S_HIGH;
                        end else if (w_cnt_last) begin
                            r_state       <= S_ARM;
                            r_timeout     <= 1'b1;
                            r_stuck_level <= r_sync2;
                        end else begin
                            r_cnt <= r_cnt + ONE;
                        end
                    end
                    default: r_state <= S_ARM;
                endcase
            end
        end
    end

    assign bus.period      = r_period;
    assign bus.high_time   = r_high_time;
    assign bus.meas_valid  = r_meas_valid;
    assign bus.timeout     = r_timeout;
    assign bus.stuck_level = r_stuck_level;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: timestamp-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized PWM streams.
module tb_pwm_capture;

    localparam int CNT_W   = 24;
    localparam int TIMEOUT = 2000;

    logic clk;
    logic rstn;

    pwm_capture_if #(.CNT_W(CNT_W)) bus ();

    pwm_capture #(
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: pwm_in as sampled on every edge, and the edge indices of
    // the last rise / fall that the block acts on (two edges after first sampling).
    int               cyc = 0;
    bit               smp[$] = '{1'b0, 1'b0, 1'b0};
    bit               m_meas = 1'b0;
    bit               m_have_fall = 1'b0;
    int               m_t_rise = 0;
    int               m_high = 0;
    logic [CNT_W-1:0] e_period = '0;
    logic [CNT_W-1:0] e_high = '0;
    logic             e_valid = 1'b0;
    logic             e_timeout = 1'b0;
    logic             e_stuck = 1'b0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            smp         = '{1'b0, 1'b0, 1'b0};
            m_meas      = 1'b0;
            m_have_fall = 1'b0;
            e_period    = '0;
            e_high      = '0;
            e_valid     = 1'b0;
            e_timeout   = 1'b0;
            e_stuck     = 1'b0;
        end else begin
            bit rise_ev;
            bit fall_ev;
            cyc++;
            smp.push_back(bus.pwm_in);
            rise_ev = smp[1] && !smp[0];
            fall_ev = !smp[1] && smp[0];
            e_valid = 1'b0;
            if (!bus.en) begin
                m_meas = 1'b0;
            end else if (!m_meas) begin
                if (rise_ev) begin
                    m_meas      = 1'b1;
                    m_have_fall = 1'b0;
                    m_t_rise    = cyc;
                end
            end else if (!m_have_fall && fall_ev) begin
                m_have_fall = 1'b1;
                m_high      = cyc - m_t_rise;
            end else if (m_have_fall && rise_ev) begin
                e_period    = CNT_W'(cyc - m_t_rise);
                e_high      = CNT_W'(m_high);
                e_valid     = 1'b1;
                e_timeout   = 1'b0;
                m_t_rise    = cyc;
                m_have_fall = 1'b0;
            end else if (cyc - m_t_rise == TIMEOUT) begin
                m_meas    = 1'b0;
                e_timeout = 1'b1;
                e_stuck   = smp[1];
            end
            void'(smp.pop_front());
        end
    end

    function automatic logic [63:0] dut_outs();
        return 64'({bus.period, bus.high_time, bus.meas_valid, bus.timeout, bus.stuck_level});
    endfunction

    function automatic logic [63:0] model_outs();
        return 64'({e_period, e_high, e_valid, e_timeout, e_stuck});
    endfunction

    always @(negedge clk) begin
        check("cycle_outputs", dut_outs(), model_outs());
    end

    // Event log used by the directed scenarios.
    int valid_q[$];
    int to_cyc  = -1;
    bit prev_to = 1'b0;

    always @(negedge clk) begin
        if (bus.meas_valid === 1'b1) valid_q.push_back(cyc);
        if (bus.timeout === 1'b1 && !prev_to) to_cyc = cyc;
        prev_to = (bus.timeout === 1'b1);
    end

    function automatic int vt(input int idx);
        if (idx >= 0 && idx < valid_q.size()) return valid_q[idx];
        return -1;
    endfunction

    task automatic drive(input bit v, input int n);
        bus.pwm_in = v;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pwm_periods(input int hi, input int lo, input int reps);
        repeat (reps) begin
            drive(1'b1, hi);
            drive(1'b0, lo);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int k;
        rstn       = 1'b1;
        bus.en     = 1'b0;
        bus.pwm_in = 1'b0;
        #1 rstn = 1'b0;
        #1 check("reset_outputs", dut_outs(), 64'd0);
        repeat (3) @(posedge clk);
        #2;
        rstn   = 1'b1;
        bus.en = 1'b1;
        drive(1'b0, 10);

        // 300 high / 700 low: first valid on the second rise, then every 1000 cycles
        base = valid_q.size();
        k    = cyc + 1;
        pwm_periods(300, 700, 3);
        drive(1'b1, 10);
        check("s33_valid_count", 64'(valid_q.size() - base), 64'd3);
        check("s33_first_valid", 64'(vt(base) - k), 64'd1002);
        check("s33_spacing", 64'(vt(base + 2) - vt(base + 1)), 64'd1000);
        check("s33_period", 64'(bus.period), 64'd1000);
        check("s33_high_time", 64'(bus.high_time), 64'd300);
        check("s33_model_period", 64'(e_period), 64'd1000);
        check("s33_model_high", 64'(e_high), 64'd300);
        drive(1'b0, 20);

        // 1 high / 9 low: narrowest high phase
        base = valid_q.size();
        k    = cyc + 1;
        pwm_periods(1, 9, 5);
        check("s34_valid_count", 64'(valid_q.size() - base), 64'd5);
        check("s34_second_valid", 64'(vt(base + 1) - k), 64'd12);
        check("s34_spacing", 64'(vt(base + 4) - vt(base + 3)), 64'd10);
        check("s34_period", 64'(bus.period), 64'd10);
        check("s34_high_time", 64'(bus.high_time), 64'd1);

        // Rise then stuck high: timeout exactly TIMEOUT cycles after the rise event
        k = cyc + 1;
        drive(1'b1, 2100);
        check("s35_timeout_time", 64'(to_cyc - k), 64'd2002);
        check("s35_timeout", 64'(bus.timeout), 64'd1);
        check("s35_stuck_level", 64'(bus.stuck_level), 64'd1);
        check("s35_period_held", 64'(bus.period), 64'd10);
        check("s35_high_held", 64'(bus.high_time), 64'd1);

        // Period exactly TIMEOUT: rise wins; then period TIMEOUT+1: timeout while low
        drive(1'b0, 10);
        base = valid_q.size();
        pwm_periods(500, 1500, 3);
        drive(1'b1, 10);
        check("s36_valid_count", 64'(valid_q.size() - base), 64'd3);
        check("s36_period", 64'(bus.period), 64'd2000);
        check("s36_high_time", 64'(bus.high_time), 64'd500);
        check("s36_timeout_clear", 64'(bus.timeout), 64'd0);
        drive(1'b1, 490);
        drive(1'b0, 1501);
        drive(1'b1, 500);
        check("s36_timeout_2001", 64'(bus.timeout), 64'd1);
        check("s36_stuck_low", 64'(bus.stuck_level), 64'd0);
        check("s36_period_held", 64'(bus.period), 64'd2000);
        check("s36_no_new_valid", 64'(valid_q.size() - base), 64'd3);

        // Reset in the middle of a high phase
        drive(1'b0, 200);
        pwm_periods(300, 700, 2);
        drive(1'b1, 100);
        rstn = 1'b0;
        #1 check("s37_async_clear", dut_outs(), 64'd0);
        drive(1'b0, 3);
        rstn = 1'b1;
        base = valid_q.size();
        drive(1'b0, 20);
        k = cyc + 1;
        pwm_periods(300, 700, 2);
        drive(1'b1, 10);
        check("s37_valid_count", 64'(valid_q.size() - base), 64'd2);
        check("s37_first_valid", 64'(vt(base) - k), 64'd1002);
        check("s37_period", 64'(bus.period), 64'd1000);

        // Enable dropped for 500 cycles mid-stream
        drive(1'b1, 290);
        drive(1'b0, 700);
        drive(1'b1, 200);
        base   = valid_q.size();
        bus.en = 1'b0;
        drive(1'b1, 100);
        drive(1'b0, 400);
        check("s38_no_valid_en0", 64'(valid_q.size() - base), 64'd0);
        check("s38_period_held", 64'(bus.period), 64'd1000);
        check("s38_high_held", 64'(bus.high_time), 64'd300);
        bus.en = 1'b1;
        drive(1'b0, 300);
        k = cyc + 1;
        pwm_periods(300, 700, 2);
        drive(1'b1, 10);
        check("s38_valid_count", 64'(valid_q.size() - base), 64'd2);
        check("s38_first_valid", 64'(vt(base) - k), 64'd1002);

        // Random streams, including lengths straddling the timeout and enable drops
        for (int i = 0; i < 120; i++) begin
            int hi;
            int lo;
            hi = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1995, 2005))
                                              : int'($urandom_range(1, 60));
            lo = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1995, 2005))
                                              : int'($urandom_range(1, 60));
            bus.en = ($urandom_range(0, 7) != 0);
            drive(1'b1, hi);
            drive(1'b0, lo);
        end
        bus.en = 1'b1;
        drive(1'b0, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 The block SHALL expose parameter CNT_W, default 24, giving the width of the period and high-time counters and outputs.
REQ-002 The block SHALL expose parameter TIMEOUT, default 2_500_000, the number of clk cycles without an expected edge (50 ms at 50 MHz) before a timeout.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: clk and rstn.
REQ-004 clk  input  1  system clock, 50 MHz.
REQ-005 rstn  input  1  asynchronous active-low reset.
REQ-006 en  input  1  capture enable; low forces the block back to idle.
REQ-007 pwm_in  input  1  external PWM signal, asynchronous to clk.
REQ-008 period  output  CNT_W  clk cycles from one rising edge to the next, from the last valid measurement.
REQ-009 high_time  output  CNT_W  clk cycles from a rising edge to the following falling edge, from the last valid measurement.
REQ-010 meas_valid  output  1  one-cycle pulse when period/high_time update.
REQ-011 timeout  output  1  level: no edge arrived within TIMEOUT cycles.
REQ-012 stuck_level  output  1  synchronized pwm_in level captured when timeout was set.

Function
REQ-013 pwm_in SHALL pass through a 2-FF synchronizer plus one history register, and rise/fall events SHALL be derived from them.
REQ-014 A pwm_in transition first sampled at clk edge k SHALL be acted on (state and outputs updated) at edge k+2.
REQ-015 The FSM SHALL have exactly three states:
- ARM: waiting for the first rising event.
- HIGH: counting the high phase.
- LOW: counting the low phase.
REQ-016 In ARM, a rise event SHALL clear the counter to 0 and go to HIGH; no output update occurs.
REQ-017 The counter SHALL increment by 1 every cycle in HIGH and LOW.
REQ-018 In HIGH, a fall event SHALL latch count+1 internally as the pending high time and go to LOW.
REQ-019 In LOW, a rise event SHALL:
- load period = count+1 and high_time = the pending high time;
- assert meas_valid for that one cycle;
- clear timeout;
- clear the counter to 0 and go to HIGH.
REQ-020 For a rise at event cycle t0, a fall at t1 and a rise at t2, the outputs SHALL be high_time = t1-t0 and period = t2-t0.
REQ-021 The first meas_valid after arming SHALL occur on the second rising event, never on the first.
REQ-022 Timeout condition: in HIGH or LOW, counter == TIMEOUT-1 with no event in the same cycle.
REQ-023 On a timeout the block SHALL:
- go to ARM;
- set timeout=1;
- set stuck_level to the synchronized pwm_in level;
- leave period and high_time holding their previous values.
REQ-024 An edge event in the same cycle as the timeout condition SHALL take priority, so no timeout occurs.
REQ-025 The parameter check SHALL enforce TIMEOUT <= 2^CNT_W - 1, so the counter never wraps.
REQ-026 A 1-cycle high phase after synchronization SHALL yield high_time = 1; an event-to-event spacing of one cycle is legal.
REQ-027 en=0 SHALL:
- force ARM on the next edge;
- suppress meas_valid;
- hold period, high_time, timeout and stuck_level.
REQ-028 After en returns to 1, capture SHALL re-arm as in REQ-016.
REQ-029 meas_valid SHALL never be high for two consecutive cycles.

Reset
REQ-030 While rstn=0, asynchronously, all of the following SHALL be 0:
- synchronizer and history registers;
- counter and pending high time;
- period and high_time;
- meas_valid, timeout and stuck_level.
REQ-031 While rstn=0 the state SHALL be ARM.
REQ-032 Reset asserted mid-measurement SHALL discard the partial measurement, and no meas_valid SHALL follow release until two new rising events have occurred.

Verification
REQ-033 The bench SHALL cover: en=1, pwm 300 high / 700 low repeating -> first meas_valid at the second rise, then one per 1000 cycles with period=1000 and high_time=300.
REQ-034 The bench SHALL cover: high 1 / low 9 cycles -> high_time=1, period=10, with meas_valid pulses spaced exactly 10 cycles.
REQ-035 The bench SHALL cover: TIMEOUT=2000, pwm_in held high after a rise -> timeout=1 and stuck_level=1 exactly 2000 cycles after the rise event, with period/high_time unchanged.
REQ-036 The bench SHALL cover: TIMEOUT=2000, period exactly 2000 (rise coincides with the timeout condition) -> no timeout and period=2000; period 2001 -> timeout.
REQ-037 The bench SHALL cover: rstn pulsed low mid-HIGH phase -> all outputs 0 immediately, and the next meas_valid comes one full period after the first post-reset rise.
REQ-038 The bench SHALL cover: en dropped for 500 cycles mid-stream -> no meas_valid while en=0, outputs hold, and the first valid comes on the second rise after en=1.
